// File: rtl/demux_4_32_fifo.sv
// demux_4_32_fifo
//   Buffered 1-to-4 demultiplexer for 32-bit words. Each accepted input word
//   is queued in the FIFO of the lane chosen by in_sel. Each lane drains
//   independently, so a stalled consumer only blocks words addressed to it.
//   A synchronous flush empties every lane.
//
// Ports
//   clk                 single clock, rising edge
//   rst_n               asynchronous active-low reset
//   flush               synchronous clear of all lanes (beats push/pop)
//   in_valid/in_ready   producer handshake; in_ready reflects selected lane
//   in_sel[1:0]         destination lane
//   in_data[31:0]       payload
//   out_valid[3:0]      bit i: lane i non-empty
//   out_ready[3:0]      bit i: consumer i takes head word
//   out_data0..3        head word of each lane, 0 when the lane is empty
//   busy                any lane non-empty
module demux_4_32_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_sel,
  input  logic [31:0] in_data,
  output logic [3:0]  out_valid,
  input  logic [3:0]  out_ready,
  output logic [31:0] out_data0,
  output logic [31:0] out_data1,
  output logic [31:0] out_data2,
  output logic [31:0] out_data3,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   mem_q    [4][DEPTH];
  logic [AW-1:0] wr_ptr_q [4];
  logic [AW-1:0] wr_ptr_d [4];
  logic [AW-1:0] rd_ptr_q [4];
  logic [AW-1:0] rd_ptr_d [4];
  logic [CW-1:0] count_q  [4];
  logic [CW-1:0] count_d  [4];
  logic [31:0]   head     [4];
  logic [3:0]    pop;
  logic [3:0]    push_lane;
  logic          push;

  // Readiness depends only on the selected lane's occupancy; a full lane
  // never passes a word through even if its consumer pops this cycle.
  assign in_ready = !flush && (count_q[in_sel] != FULL);
  assign push     = in_valid && in_ready;

  always_comb begin
    out_valid = '0;
    pop       = '0;
    push_lane = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      out_valid[i] = (count_q[i] != '0);
      pop[i]       = (count_q[i] != '0) && out_ready[i];
      push_lane[i] = push && (in_sel == 2'(i));
      head[i]      = (count_q[i] != '0) ? mem_q[i][rd_ptr_q[i]] : '0;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (push_lane[i]) wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
      if (pop[i])       rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      case ({push_lane[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + 1'b1;
        2'b01:   count_d[i] = count_q[i] - 1'b1;
        default: count_d[i] = count_q[i];
      endcase
      if (flush) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        count_d[i]  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

  // Storage is not reset; contents are only observed through count != 0.
  always_ff @(posedge clk) begin
    if (push) mem_q[in_sel][wr_ptr_q[in_sel]] <= in_data;
  end

  assign out_data0 = head[0];
  assign out_data1 = head[1];
  assign out_data2 = head[2];
  assign out_data3 = head[3];
  assign busy      = |out_valid;

endmodule

// File: tb/tb_demux_4_32_fifo.sv
module tb_demux_4_32_fifo;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [31:0] in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data0, out_data1, out_data2, out_data3;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one queue of words per lane.
  logic [31:0] q0[$], q1[$], q2[$], q3[$];

  demux_4_32_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lane_size(input int l);
    case (l)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [31:0] lane_head(input int l);
    if (lane_size(l) == 0) return 32'h0;
    case (l)
      0: return q0[0];
      1: return q1[0];
      2: return q2[0];
      default: return q3[0];
    endcase
  endfunction

  task automatic model_clear();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
  endtask

  task automatic check_outputs(input logic [1:0] s, input logic f);
    logic [3:0] ev;
    for (int l = 0; l < 4; l++) ev[l] = (lane_size(l) != 0);
    check("out_valid", 32'(out_valid), 32'(ev));
    check("busy", 32'(busy), 32'(|ev));
    check("in_ready", 32'(in_ready), 32'(!f && (lane_size(int'(s)) < DEPTH)));
    check("out_data0", out_data0, lane_head(0));
    check("out_data1", out_data1, lane_head(1));
    check("out_data2", out_data2, lane_head(2));
    check("out_data3", out_data3, lane_head(3));
  endtask

  // One clock cycle: drive after the falling edge, check, advance the model,
  // then let the rising edge happen.
  task automatic step(input logic v, input logic [1:0] s, input logic [31:0] d,
                      input logic [3:0] r, input logic f);
    logic do_push;
    @(negedge clk);
    in_valid = v; in_sel = s; in_data = d; out_ready = r; flush = f;
    #1;
    check_outputs(s, f);
    if (f) begin
      model_clear();
    end else begin
      do_push = v && (lane_size(int'(s)) < DEPTH);
      if (r[0] && q0.size() != 0) void'(q0.pop_front());
      if (r[1] && q1.size() != 0) void'(q1.pop_front());
      if (r[2] && q2.size() != 0) void'(q2.pop_front());
      if (r[3] && q3.size() != 0) void'(q3.pop_front());
      if (do_push) begin
        case (s)
          2'd0: q0.push_back(d);
          2'd1: q1.push_back(d);
          2'd2: q2.push_back(d);
          default: q3.push_back(d);
        endcase
      end
    end
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sel = 2'd0;
    in_data = '0; out_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Reset mid-cycle with lane 2 holding two words.
    step(1, 2, 32'hC1, 4'h0, 0);
    step(1, 2, 32'hC2, 4'h0, 0);
    @(negedge clk); in_valid = 0;
    #1;
    check("pre_reset_valid", 32'(out_valid), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data2", out_data2, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    model_clear();
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h1);

    // Routing to all four lanes.
    for (int i = 0; i < 4; i++) step(1, 2'(i), 32'hA000_0000 + 32'(i), 4'h0, 0);
    step(0, 0, 0, 4'h0, 0);
    check("route_valid", 32'(out_valid), 32'hF);
    check("route_d3", out_data3, 32'hA000_0003);
    step(0, 0, 0, 4'h0, 1);

    // Full lane 1, then a single pop.
    step(1, 1, 32'h11, 4'h0, 0);
    step(1, 1, 32'h22, 4'h0, 0);
    step(1, 1, 32'h33, 4'h0, 0);      // refused: lane 1 full
    step(0, 3, 0, 4'h0, 0);           // lane 3 still ready
    step(0, 1, 0, 4'h2, 0);           // pop 0x11
    step(0, 1, 0, 4'h0, 0);
    check("full_pop_d1", out_data1, 32'h22);
    step(0, 0, 0, 4'h0, 1);

    // Simultaneous push and pop on one lane.
    step(1, 0, 32'h5, 4'h0, 0);
    step(1, 0, 32'h6, 4'h1, 0);
    step(0, 0, 0, 4'h0, 0);
    check("pushpop_d0", out_data0, 32'h6);
    step(0, 0, 0, 4'h0, 1);

    // Wrap-around through lane 3.
    for (int k = 1; k <= 10; k++) step(1, 3, 32'(k), 4'h8, 0);
    step(0, 3, 0, 4'h8, 0);
    step(0, 3, 0, 4'h8, 0);

    // Flush with all lanes full.
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < DEPTH; k++) step(1, 2'(l), 32'h100 * 32'(l) + 32'(k), 4'h0, 0);
    step(1, 2, 32'hDEAD, 4'hF, 1);
    step(1, 2, 32'h77, 4'h0, 0);
    step(0, 0, 0, 4'h0, 0);
    check("flush_valid", 32'(out_valid), 32'h4);
    check("flush_d2", out_data2, 32'h77);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom,
           4'($urandom), 1'($urandom_range(0, 63) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
